// File: rtl/microwave_pkg.sv
// Shared types and constants for the microwave controller.
// Digit bundle is ordered MM:SS, most significant first.
package microwave_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ENTRY = 3'd1,
    RUN   = 3'd2,
    PAUSE = 3'd3,
    DONE  = 3'd4
  } state_t;

  localparam logic [3:0] BCD_NINE        = 4'd9;
  localparam logic [3:0] SEC_RELOAD_TENS = 4'd5;

  typedef struct packed {
    logic [3:0] mt;
    logic [3:0] mo;
    logic [3:0] st;
    logic [3:0] so;
  } mmss_t;

endpackage

// File: rtl/bcd_mmss_dec.sv
// One-second BCD MM:SS decrement with zero detect on the result.
// Seconds above 59 count down as entered; borrows reload 59.
module bcd_mmss_dec
  import microwave_pkg::*;
(
  input  mmss_t cur,
  output mmss_t nxt,
  output logic  is_zero_next
);

  always_comb begin
    nxt = cur;
    priority case (1'b1)
      cur.so != 4'd0: begin
        nxt.so = cur.so - 4'd1;
      end
      cur.st != 4'd0: begin
        nxt.st = cur.st - 4'd1;
        nxt.so = BCD_NINE;
      end
      cur.mo != 4'd0: begin
        nxt.mo = cur.mo - 4'd1;
        nxt.st = SEC_RELOAD_TENS;
        nxt.so = BCD_NINE;
      end
      cur.mt != 4'd0: begin
        nxt.mt = cur.mt - 4'd1;
        nxt.mo = BCD_NINE;
        nxt.st = SEC_RELOAD_TENS;
        nxt.so = BCD_NINE;
      end
      default: begin
        nxt = cur;
      end
    endcase
    is_zero_next = (nxt == '0);
  end

endmodule

// File: rtl/cook_timer.sv
// Keypad digit capture and MM:SS countdown for the microwave.
// Keypad is locked (enbn=1) while cooking or paused.
module cook_timer
  import microwave_pkg::*;
#(
  parameter int CLK_PER_SEC = 100
) (
  input  logic       clk,
  input  logic       clrn,
  input  logic [3:0] D,
  input  logic       loadn,
  input  logic       start,
  input  logic       stop,
  output logic [3:0] min_tens,
  output logic [3:0] min_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] sec_ones,
  output logic       running,
  output logic       done,
  output logic       enbn
);

  localparam int PW = $clog2(CLK_PER_SEC);
  localparam logic [PW-1:0] LAST = PW'(CLK_PER_SEC - 1);

  state_t        state, state_n;
  mmss_t         dig, dig_n, dig_dec, dig_sh, dig_new;
  logic [PW-1:0] pre, pre_n;
  logic          loadn_q;
  logic          load_ok;
  logic          tick;
  logic          dec_zero;
  logic          done_q, done_n;

  bcd_mmss_dec u_dec (
    .cur          (dig),
    .nxt          (dig_dec),
    .is_zero_next (dec_zero)
  );

  // One event per low pulse; non-BCD digits are dropped.
  assign load_ok = loadn_q & ~loadn & (D <= BCD_NINE);
  assign tick    = (pre == LAST);

  always_comb begin
    dig_sh    = dig;
    dig_sh.mt = dig.mo;
    dig_sh.mo = dig.st;
    dig_sh.st = dig.so;
    dig_sh.so = D;
    dig_new    = '0;
    dig_new.so = D;
  end

  always_ff @(posedge clk) begin
    if (!clrn) begin
      state   <= IDLE;
      dig     <= '0;
      pre     <= '0;
      loadn_q <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state   <= state_n;
      dig     <= dig_n;
      pre     <= pre_n;
      loadn_q <= loadn;
      done_q  <= done_n;
    end
  end

  always_comb begin
    state_n = state;
    dig_n   = dig;
    pre_n   = pre;
    done_n  = 1'b0;
    unique case (state)
      IDLE: begin
        if (load_ok) begin
          dig_n   = dig_sh;
          state_n = ENTRY;
        end
      end
      ENTRY: begin
        if (stop) begin
          dig_n   = '0;
          state_n = IDLE;
        end else if (start) begin
          if (dig != '0) begin
            pre_n   = '0;
            state_n = RUN;
          end
        end else if (load_ok) begin
          dig_n = dig_sh;
        end
      end
      RUN: begin
        if (stop) begin
          state_n = PAUSE;
        end else if (tick) begin
          pre_n = '0;
          dig_n = dig_dec;
          if (dec_zero) begin
            state_n = DONE;
            done_n  = 1'b1;
          end
        end else begin
          pre_n = pre + 1'b1;
        end
      end
      PAUSE: begin
        if (stop) begin
          dig_n   = '0;
          state_n = IDLE;
        end else if (start) begin
          state_n = RUN;
        end
      end
      DONE: begin
        if (stop) begin
          state_n = IDLE;
        end else if (load_ok) begin
          dig_n   = dig_new;
          state_n = ENTRY;
        end
      end
      default: begin
        dig_n   = '0;
        pre_n   = '0;
        state_n = IDLE;
      end
    endcase
  end

  assign min_tens = dig.mt;
  assign min_ones = dig.mo;
  assign sec_tens = dig.st;
  assign sec_ones = dig.so;
  assign running  = (state == RUN);
  assign enbn     = (state == RUN) || (state == PAUSE);
  assign done     = done_q;

endmodule

// File: tb/tb_cook_timer.sv
// Bench for cook_timer: directed plan with literal checks, then
// random stimulus against an arithmetic MM:SS reference model.
module tb_cook_timer;

  logic       clk;
  logic       clrn;
  logic [3:0] D;
  logic       loadn;
  logic       start;
  logic       stop;
  logic [3:0] min_tens, min_ones, sec_tens, sec_ones;
  logic       running, done, enbn;

  int n_cmp = 0;
  int n_bad = 0;

  cook_timer #(.CLK_PER_SEC(4)) dut (
    .clk      (clk),
    .clrn     (clrn),
    .D        (D),
    .loadn    (loadn),
    .start    (start),
    .stop     (stop),
    .min_tens (min_tens),
    .min_ones (min_ones),
    .sec_tens (sec_tens),
    .sec_ones (sec_ones),
    .running  (running),
    .done     (done),
    .enbn     (enbn)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  wire [15:0] dut_dig = {min_tens, min_ones, sec_tens, sec_ones};

  // Model: value kept as a 4-digit decimal number MMSS.
  localparam int M_IDLE  = 0;
  localparam int M_ENTRY = 1;
  localparam int M_RUN   = 2;
  localparam int M_PAUSE = 3;
  localparam int M_DONE  = 4;

  int m_st  = M_IDLE;
  int m_v   = 0;
  int m_pre = 0;
  bit m_lq  = 1'b1;
  bit m_done = 1'b0;
  bit m_ok;

  function automatic int dec_val(input int v);
    int mm, ss;
    mm = v / 100;
    ss = v % 100;
    if (ss > 0) return v - 1;
    if (mm > 0) return (mm - 1) * 100 + 59;
    return 0;
  endfunction

  function automatic logic [15:0] to_bcd(input int v);
    return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  always @(posedge clk) begin
    m_ok = m_lq && !loadn && (D <= 4'd9);
    if (!clrn) begin
      m_st = M_IDLE; m_v = 0; m_pre = 0; m_lq = 1'b1; m_done = 1'b0;
    end else begin
      m_done = 1'b0;
      case (m_st)
        M_IDLE: if (m_ok) begin
          m_v = (m_v % 1000) * 10 + int'(D); m_st = M_ENTRY;
        end
        M_ENTRY: begin
          if (stop) begin m_v = 0; m_st = M_IDLE; end
          else if (start) begin
            if (m_v != 0) begin m_st = M_RUN; m_pre = 0; end
          end else if (m_ok) m_v = (m_v % 1000) * 10 + int'(D);
        end
        M_RUN: begin
          if (stop) m_st = M_PAUSE;
          else if (m_pre == 3) begin
            m_pre = 0;
            m_v = dec_val(m_v);
            if (m_v == 0) begin m_st = M_DONE; m_done = 1'b1; end
          end else m_pre = m_pre + 1;
        end
        M_PAUSE: begin
          if (stop) begin m_v = 0; m_st = M_IDLE; end
          else if (start) m_st = M_RUN;
        end
        default: begin
          if (stop) m_st = M_IDLE;
          else if (m_ok) begin m_v = int'(D); m_st = M_ENTRY; end
        end
      endcase
      m_lq = loadn;
    end
  end

  task automatic check(input string nm, input logic [15:0] got,
                       input logic [15:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    check("model_digits", dut_dig, to_bcd(m_v));
    check("model_running", 16'(running), 16'(m_st == M_RUN));
    check("model_done", 16'(done), 16'(m_done));
    check("model_enbn", 16'(enbn), 16'(m_st == M_RUN || m_st == M_PAUSE));
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic load_pulse(input logic [3:0] d, input int len);
    loadn = 1'b0; D = d;
    cyc(len);
    loadn = 1'b1;
    cyc(1);
  endtask

  task automatic pulse_start();
    start = 1'b1; cyc(1); start = 1'b0;
  endtask

  task automatic pulse_stop();
    stop = 1'b1; cyc(1); stop = 1'b0;
  endtask

  initial begin
    clrn = 1'b0; D = 4'd0; loadn = 1'b1; start = 1'b0; stop = 1'b0;
    cyc(2);
    clrn = 1'b1;
    check("reset_digits", dut_dig, 16'h0000);
    check("reset_flags", {13'd0, running, done, enbn}, 16'h0000);

    load_pulse(4'd9, 5); load_pulse(4'd8, 5); load_pulse(4'd1, 5);
    check("entry_0981", dut_dig, 16'h0981);
    check("entry_enbn", 16'(enbn), 16'h0000);

    pulse_start();
    check("run_flags", {14'd0, running, enbn}, 16'h0003);
    cyc(3);
    check("pre_tick", dut_dig, 16'h0981);
    cyc(1);
    check("first_tick", dut_dig, 16'h0980);
    cyc(320);
    check("at_0900", dut_dig, 16'h0900);
    cyc(4);
    check("borrow_0859", dut_dig, 16'h0859);
    pulse_stop(); pulse_stop();
    check("stopped_idle", {dut_dig[14:0], enbn}, 16'h0000);

    load_pulse(4'd0, 2); load_pulse(4'd0, 2);
    load_pulse(4'd0, 2); load_pulse(4'd2, 2);
    pulse_start();
    cyc(4);
    check("count_0001", dut_dig, 16'h0001);
    cyc(3);
    check("hold_0001", dut_dig, 16'h0001);
    cyc(1);
    check("reach_zero", dut_dig, 16'h0000);
    check("done_flags", {13'd0, running, done, enbn}, 16'h0002);
    cyc(1);
    check("done_once", 16'(done), 16'h0000);

    load_pulse(4'd4, 3); load_pulse(4'd5, 3);
    check("reload_0045", dut_dig, 16'h0045);
    pulse_start();
    cyc(2);
    pulse_stop();
    check("pause_flags", {14'd0, running, enbn}, 16'h0001);
    cyc(20);
    load_pulse(4'd3, 4);
    cyc(20);
    check("pause_frozen", dut_dig, 16'h0045);
    pulse_start();
    cyc(1);
    check("resume_hold", dut_dig, 16'h0045);
    cyc(1);
    check("resume_0044", dut_dig, 16'h0044);
    pulse_stop(); pulse_stop();
    check("pause_clear", {dut_dig[14:0], enbn}, 16'h0000);

    load_pulse(4'd0, 1); load_pulse(4'd1, 1);
    load_pulse(4'd0, 1); load_pulse(4'd0, 1);
    check("entry_0100", dut_dig, 16'h0100);
    start = 1'b1; stop = 1'b1; cyc(1); start = 1'b0; stop = 1'b0;
    check("startstop", {dut_dig[14:0], running}, 16'h0000);
    load_pulse(4'd0, 1);
    pulse_start();
    check("zero_start", 16'(running), 16'h0000);
    load_pulse(4'd7, 2); load_pulse(4'hA, 2);
    check("bad_digit", dut_dig, 16'h0007);

    pulse_stop();
    load_pulse(4'd0, 1); load_pulse(4'd5, 1);
    load_pulse(4'd3, 1); load_pulse(4'd0, 1);
    pulse_start();
    cyc(6);
    clrn = 1'b0; cyc(1); clrn = 1'b1;
    check("midrun_rst", {dut_dig[12:0], running, done, enbn}, 16'h0000);

    // Random phase: short counts keep DONE reachable.
    for (int i = 0; i < 4000; i++) begin
      if (loadn) begin
        if ($urandom_range(0, 3) == 0) begin
          loadn = 1'b0;
          D = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(10, 15))
                                          : 4'($urandom_range(0, 2));
        end
      end else if ($urandom_range(0, 2) == 0) begin
        loadn = 1'b1;
      end
      start = ($urandom_range(0, 7) == 0);
      stop  = ($urandom_range(0, 24) == 0);
      clrn  = ($urandom_range(0, 499) != 0);
      cyc(1);
    end
    clrn = 1'b1; loadn = 1'b1; start = 1'b0; stop = 1'b0;
    cyc(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/cook_timer.md
Name: cook_timer

Overview:
- Downstream consumer of the keypad encoder in the microwave controller.
- Captures each BCD digit strobed by the encoder (D, loadn) into a 4-digit MM:SS entry register, shifting digits in from the right.
- On start, counts the value down once per second, asserting running while the magnetron runs. Pulses done at 00:00.
- Drives the encoder's enbn so the keypad is locked while cooking or paused.

Parameters:
- CLK_PER_SEC, 100, clk cycles per one-second decrement (internal prescaler); must be >=2.

Ports:
- clk  in  1  system clock, all logic on rising edge
- clrn  in  1  synchronous active-low reset
- D  in  4  BCD digit from encoder
- loadn  in  1  encoder load strobe, active low, may stay low several cycles
- start  in  1  start/resume button, level, sampled each cycle
- stop  in  1  stop/cancel button, level, sampled each cycle
- min_tens, min_ones, sec_tens, sec_ones  out  4 each  displayed BCD digits
- running  out  1  high in RUN state only
- done  out  1  one-cycle pulse on entering DONE
- enbn  out  1  to encoder; 1 (keypad disabled) in RUN and PAUSE, else 0

Behaviour:
- Clock/reset: one clock (clk); reset is synchronous and active-low (clrn). Reset mid-operation aborts immediately.
- Reset values: all digits 0, state IDLE, running=0, done=0, enbn=0, prescaler=0, loadn_q=1.
- Load event: load_ev = loadn_q & ~loadn, where loadn_q is loadn registered. Exactly one event per low pulse, regardless of pulse length. D>9 on a load event is ignored, with no shift.
- Shift on accepted load: min_tens<=min_ones, min_ones<=sec_tens, sec_tens<=sec_ones, sec_ones<=D. Visible on outputs the cycle after the edge where load_ev=1.
- Event priority within one cycle: stop > start > tick > load.
- States and transitions:
  - IDLE (digits 0): load -> shift, go to ENTRY.
  - ENTRY:
    - load -> shift.
    - start with value !=0000 -> RUN, prescaler cleared to 0.
    - start with 0000 -> stay.
    - stop -> clear digits, go to IDLE.
  - RUN:
    - prescaler increments each cycle. When it equals CLK_PER_SEC-1 it wraps to 0 and the value is decremented (tick).
    - If the decremented result is 0000 -> DONE.
    - stop -> PAUSE, prescaler held.
    - load and start are ignored.
  - PAUSE:
    - start -> RUN, prescaler resumes from held value.
    - stop -> clear digits, go to IDLE.
    - load is ignored.
  - DONE:
    - digits remain 0000, done=1 for the single entry cycle only.
    - load -> digits cleared, then the new digit shifted in (result 000D), go to ENTRY.
    - stop -> IDLE.
- Start in the same cycle as a would-be tick: no decrement. The first decrement occurs CLK_PER_SEC cycles after entering RUN.
- Decrement rule (BCD MM:SS):
  - sec_ones>0: decrement sec_ones.
  - else sec_tens>0: decrement sec_tens, sec_ones=9.
  - else minutes>0: decrement minutes as 2-digit BCD (borrow min_tens when min_ones=0), seconds=59.
- Seconds entered above 59 (e.g. 81) are not normalised. They count down as entered, and borrows reload 59.
- Maximum entry is 99:99. No overflow is possible because shifting discards min_tens.
- Held start or stop levels re-trigger only as the state rules above allow (e.g. a held stop in PAUSE clears to IDLE the next cycle).

Decomposition:
- microwave_pkg (localparams/include):
  - state encodings IDLE, ENTRY, RUN, PAUSE, DONE
  - BCD_NINE=4'd9
  - SEC_RELOAD_TENS=4'd5
- Sub-module bcd_mmss_dec: combinational. Input 4 digits; outputs the decremented 4 digits plus is_zero_next.
- cook_timer holds the FSM, prescaler, edge detector and digit registers.

Test Plan (CLK_PER_SEC=4):
- Reset, then loadn pulses with D=9, 8, 1 (each low 5 cycles) -> digits 0,9,8,1 (09:81); exactly one shift per pulse; enbn=0.
- From 09:81, start 1 cycle:
  - running=1, enbn=1 next cycle.
  - 09:80 appears after 4 cycles.
  - After 81 ticks, 09:00 is followed by 08:59.
- Enter 0,0,0,2; start -> 00:01 then 00:00 at tick 2; done=1 for one cycle; running=0; state DONE; enbn=0.
- During RUN at 00:45:
  - stop -> PAUSE; digits frozen 40+ cycles; load with D=3 ignored.
  - start -> resumes, 00:44 after the remaining prescaler count.
  - stop, stop -> IDLE, 00:00.
- start and stop asserted together in ENTRY at 01:00 -> IDLE, digits 0000, running never 1. Start with 0000 -> stays, running=0. Load with D=4'hA -> ignored.
- clrn=0 for 1 cycle mid-RUN at 05:30 -> next cycle all digits 0, running=0, done=0, enbn=0, IDLE.
